spi_master_core: RTL and testbench
==================================

Name: spi_master_core

Overview:
- Parametrised SPI master shift engine: multi-slave NSS, 8/16/24/32-bit frames, all four CPOL/CPHA modes, MSB/LSB first, programmable SCK divider.
- Adds burst transfers: NSS stays asserted across back-to-back frames.
- Sits below the APB register file, which drives config (CTRL1/CTRL2/DIV fields) and the TX/RX handshakes; drives the spi_if pins.

Parameters:
- NSS_NUM, 4, number of slave-select lines.
- DATA_WIDTH, 32, max frame width; must be a multiple of 8.
- DIV_WIDTH, 16, divider width.

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-high reset
- en_i  in  1  core enable; low aborts any frame
- cpol_i  in  1  SCK idle level
- cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge
- lsb_i  in  1  1: LSB first
- ass_i  in  1  1: hardware slave select; 0: software NSS
- dtb_i  in  2  frame length 8*(dtb_i+1) bits
- nss_i  in  NSS_NUM  slave mask, 1 = selected
- div_i  in  DIV_WIDTH  SCK half-period = div_i+1 clk cycles
- tx_valid_i  in  1  TX word offered
- tx_ready_o  out  1  TX word accepted when tx_valid_i & tx_ready_o
- tx_data_i  in  DATA_WIDTH  right-aligned TX word
- rx_valid_o  out  1  one-cycle pulse, RX word complete
- rx_data_o  out  DATA_WIDTH  right-aligned RX word, upper bits zero
- busy_o  out  1  state != IDLE
- spi_sck_o  out  1  serial clock
- spi_nss_o  out  NSS_NUM  active-low selects
- spi_mosi_o  out  1  serial out
- spi_miso_i  in  1  serial in

Behaviour:
- Reset values:
  - spi_sck_o=0, spi_nss_o=all 1, spi_mosi_o=0.
  - tx_ready_o=0, rx_valid_o=0, rx_data_o=0, busy_o=0.
  - FSM in IDLE; divider and bit counters 0.
- FSM states: IDLE, LEAD, SHIFT, TRAIL.
- IDLE:
  - spi_sck_o=cpol_i; tx_ready_o=en_i.
  - On accept, latch cpol/cpha/lsb/ass/dtb/nss/div and the TX word, then enter LEAD next cycle.
- LEAD: lasts one half-period.
  - If ass, NSS = ~nss mask from the first LEAD cycle.
  - If CPHA=0, first bit is on MOSI from the first LEAD cycle.
- SHIFT: 2N half-period ticks, N = 8*(dtb+1); SCK toggles on each tick.
  - CPHA=0: sample MISO on odd edges; shift MOSI on even edges except the last.
  - CPHA=1: shift MOSI on odd edges; sample MISO on even edges.
  - MSB-first sends bit N-1 first; LSB-first sends bit 0 first.
- End of SHIFT (final tick cycle):
  - rx_valid_o pulses for one cycle; rx_data_o updates in the same cycle and holds until the next pulse.
  - tx_ready_o=1 for that cycle only. If tx_valid_i is high and ass=1: burst — next word loaded, stay in SHIFT, NSS remains low, latched config reused.
  - Otherwise go to TRAIL.
- TRAIL: one half-period, SCK at CPOL, NSS still asserted; then NSS deasserts and FSM returns to IDLE. Minimum NSS-high gap is 1 cycle.
- Frame length without burst: (div+1)*(2N+2) clk cycles from accept to IDLE.
- Software NSS (latched ass=0, or ass_i=0 in IDLE): spi_nss_o = ~nss_i, combinational from the register input.
- Divider counter reloads every tick.
  - div=0 gives SCK = clk/2.
  - div = all-ones must not overflow; the counter is DIV_WIDTH bits, compared for equality.
- en_i low in any state: next cycle IDLE, SCK=cpol_i, NSS deasserted (ass mode), no rx_valid_o, partial RX discarded.
- Config input changes mid-frame are ignored; they take effect at the next IDLE accept.
- rx_valid_o has no backpressure; the consumer must take the word on the pulse.

Decomposition:
- Shared define/package holds:
  - state enum spi_state_e {IDLE, LEAD, SHIFT, TRAIL};
  - DTB encoding constants SPI_DTB_8/16/24/32;
  - the NSS_NUM default.
- One sub-module, spi_clkgen: DIV_WIDTH counter with enable/clear and a one-cycle tick output.
- The shift register and FSM stay in spi_master_core.

Test Plan:
- Mode 0, MSB first, dtb=0, div=1, nss=4'b0001, ass=1, tx=0xA5, MISO loopback:
  - spi_nss_o=4'b1110 for 36 cycles; MOSI bit sequence 1,0,1,0,0,1,0,1;
  - rx_data_o=0x000000A5 with one rx_valid_o pulse.
- Mode 3, LSB first, dtb=3, div=0, tx=0x12345678, MISO tied to 0x80000001 pattern:
  - 8 SCK idle-high cycles per byte, 32 edges pairs;
  - rx_data_o=0x80000001.
- Burst of two 16-bit words 0xBEEF, 0xCAFE, tx_valid_i held high:
  - NSS never deasserts between frames;
  - two rx_valid_o pulses 32*(div+1) cycles apart; two tx_ready_o pulses.
- en_i dropped at SHIFT edge 5:
  - next cycle busy_o=0, spi_nss_o=all 1, SCK=CPOL;
  - no rx_valid_o; next frame completes normally.
- ass=0, nss_i=4'b0110:
  - spi_nss_o=4'b1001 immediately, including in IDLE;
  - frame runs with NSS unchanged.
- rst_i asserted mid-frame: outputs return to reset values asynchronously, within the same cycle.

Source files
------------

// File: rtl/spi_master_core_pkg.sv
// Shared types and constants for the SPI master shift engine.
package spi_master_core_pkg;

  localparam int unsigned NSS_NUM_DEFAULT = 4;

  localparam logic [1:0] SPI_DTB_8  = 2'd0;
  localparam logic [1:0] SPI_DTB_16 = 2'd1;
  localparam logic [1:0] SPI_DTB_24 = 2'd2;
  localparam logic [1:0] SPI_DTB_32 = 2'd3;

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} spi_state_e;

  // Frame length in bits for a DTB code.
  function automatic logic [7:0] dtb_bits(input logic [1:0] dtb);
    logic [7:0] bits;
    bits = 8'd32;
    case (dtb)
      SPI_DTB_8:  bits = 8'd8;
      SPI_DTB_16: bits = 8'd16;
      SPI_DTB_24: bits = 8'd24;
      SPI_DTB_32: bits = 8'd32;
      default:    bits = 8'd32;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/spi_master_core_if.sv
// SPI pin bundle between the master core and the attached slaves.
interface spi_master_core_if
  import spi_master_core_pkg::*;
#(
  parameter int unsigned NSS_NUM = NSS_NUM_DEFAULT
);
  logic               sck;
  logic [NSS_NUM-1:0] nss;
  logic               mosi;
  logic               miso;

  modport master (output sck, output nss, output mosi, input miso);
  modport slave  (input sck, input nss, input mosi, output miso);
endinterface

// File: rtl/spi_master_core_clkgen.sv
// SCK half-period timer: free-running counter that pulses tick_o when it reaches div_i.
module spi_master_core_clkgen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  // Equality compare, so div_i = all-ones never wraps past the terminal count.
  assign tick_o = en_i & ~clr_i & (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_core.sv
// SPI master shift engine: 8..32-bit frames, all CPOL/CPHA modes, MSB/LSB first, burst NSS.
module spi_master_core
  import spi_master_core_pkg::*;
#(
  parameter int unsigned NSS_NUM    = NSS_NUM_DEFAULT,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsb_i,
  input  logic                  ass_i,
  input  logic [1:0]            dtb_i,
  input  logic [NSS_NUM-1:0]    nss_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  rx_valid_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  busy_o,
  spi_master_core_if.master     spi
);

  spi_state_e            state_q, state_d;
  logic                  sck_q, sck_d, mosi_q, mosi_d;
  logic                  cpha_q, cpha_d, lsb_q, lsb_d, ass_q, ass_d;
  logic [1:0]            dtb_q, dtb_d;
  logic [NSS_NUM-1:0]    nss_q, nss_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic [7:0]            edge_q, edge_d;

  logic                  tick, idle, frame_done, load, last_edge, samp_edge, shift_edge;
  logic [7:0]            n_bits, ld_n;
  logic                  ld_cpha, ld_lsb, hw_sel;
  logic [DATA_WIDTH-1:0] ld_word, rx_shifted, rx_word, rx_aligned;

  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] sr, input logic lsb);
    return lsb ? sr[0] : sr[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_sr(input logic [DATA_WIDTH-1:0] sr,
                                                     input logic lsb);
    return lsb ? (sr >> 1) : (sr << 1);
  endfunction

  spi_master_core_clkgen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_clkgen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (en_i & ~idle),
    .clr_i (idle),
    .div_i (div_q),
    .tick_o(tick)
  );

  assign idle       = (state_q == IDLE);
  assign n_bits     = dtb_bits(dtb_q);
  // edge_q counts completed edges; edge_q[0]==0 means the current tick is an odd edge.
  assign last_edge  = (edge_q == ((n_bits << 1) - 8'd1));
  assign samp_edge  = cpha_q ? edge_q[0] : ~edge_q[0];
  assign shift_edge = cpha_q ? ~edge_q[0] : (edge_q[0] & ~last_edge);
  assign frame_done = (state_q == SHIFT) & tick & last_edge;
  assign load       = en_i & tx_valid_i & (idle | (frame_done & ass_q));

  assign ld_cpha = idle ? cpha_i : cpha_q;
  assign ld_lsb  = idle ? lsb_i : lsb_q;
  assign ld_n    = dtb_bits(idle ? dtb_i : dtb_q);
  // MSB-first words are left-aligned so the outgoing bit is always the top bit.
  assign ld_word = ld_lsb ? tx_data_i : (tx_data_i << (8'(DATA_WIDTH) - ld_n));

  assign rx_shifted = lsb_q ? {spi.miso, rx_sr_q[DATA_WIDTH-1:1]}
                            : {rx_sr_q[DATA_WIDTH-2:0], spi.miso};
  assign rx_word    = ((state_q == SHIFT) && tick && samp_edge) ? rx_shifted : rx_sr_q;
  assign rx_aligned = lsb_q ? (rx_word >> (8'(DATA_WIDTH) - n_bits)) : rx_word;

  always_comb begin
    state_d   = state_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    ass_d     = ass_q;
    dtb_d     = dtb_q;
    nss_d     = nss_q;
    div_d     = div_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    edge_d    = edge_q;

    unique case (state_q)
      IDLE: begin
        sck_d  = cpol_i;
        edge_d = '0;
        if (load) begin
          state_d = LEAD;
          cpha_d  = cpha_i;
          lsb_d   = lsb_i;
          ass_d   = ass_i;
          dtb_d   = dtb_i;
          nss_d   = nss_i;
          div_d   = div_i;
        end
      end
      LEAD: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          sck_d  = ~sck_q;
          edge_d = edge_q + 8'd1;
          if (samp_edge) rx_sr_d = rx_shifted;
          if (shift_edge) begin
            mosi_d  = out_bit(tx_sr_q, lsb_q);
            tx_sr_d = shift_sr(tx_sr_q, lsb_q);
          end
          if (last_edge) begin
            rx_data_d = rx_aligned;
            state_d   = load ? SHIFT : TRAIL;
          end
        end
      end
      TRAIL: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // New word: with CPHA=0 the first bit must already be on MOSI before the first edge.
    if (load) begin
      edge_d  = '0;
      rx_sr_d = '0;
      if (!ld_cpha) begin
        mosi_d  = out_bit(ld_word, ld_lsb);
        tx_sr_d = shift_sr(ld_word, ld_lsb);
      end else begin
        tx_sr_d = ld_word;
      end
    end

    if (!en_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      ass_q     <= 1'b0;
      dtb_q     <= '0;
      nss_q     <= '0;
      div_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      edge_q    <= '0;
    end else begin
      state_q   <= state_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      ass_q     <= ass_d;
      dtb_q     <= dtb_d;
      nss_q     <= nss_d;
      div_q     <= div_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      edge_q    <= edge_d;
    end
  end

  assign busy_o     = ~idle;
  assign rx_valid_o = frame_done;
  assign rx_data_o  = frame_done ? rx_aligned : rx_data_q;
  // Outputs fed straight from config inputs are forced to their reset values during rst_i.
  assign tx_ready_o = ~rst_i & en_i & (idle | frame_done);
  assign spi.sck    = ~rst_i & (idle ? cpol_i : sck_q);
  assign spi.mosi   = mosi_q;

  assign hw_sel = idle ? ass_i : ass_q;

  always_comb begin
    spi.nss = {NSS_NUM{1'b1}};
    if (!rst_i) begin
      if (!hw_sel) begin
        spi.nss = ~nss_i;
      end else if (!idle) begin
        spi.nss = ~nss_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core with a loopback path and a small SPI slave model.
module tb_spi_master_core;
  import spi_master_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb = 1'b0, ass = 1'b0;
  logic [1:0]  dtb = 2'd0;
  logic [3:0]  nss = 4'd0;
  logic [15:0] div = 16'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] tx_data = 32'd0;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        busy;

  int checks = 0;
  int failures = 0;

  spi_master_core_if #(.NSS_NUM(4)) spi ();

  spi_master_core #(
    .NSS_NUM(4),
    .DATA_WIDTH(32),
    .DIV_WIDTH(16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .cpol_i    (cpol),
    .cpha_i    (cpha),
    .lsb_i     (lsb),
    .ass_i     (ass),
    .dtb_i     (dtb),
    .nss_i     (nss),
    .div_i     (div),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .tx_data_i (tx_data),
    .rx_valid_o(rx_valid),
    .rx_data_o (rx_data),
    .busy_o    (busy),
    .spi       (spi.master)
  );

  always #5 clk = ~clk;

  // MISO source: loopback of MOSI or the slave model
  logic loop = 1'b0;
  logic slv_miso = 1'b0;
  assign spi.miso = loop ? spi.mosi : slv_miso;

  // Slave model: samples/drives on SCK edges according to its own mode settings
  logic        slv_on = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
  logic [31:0] slv_tx = 32'd0, slv_rx = 32'd0;
  int          slv_bits = 8, slv_d = 0, slv_s = 0;

  task automatic slave_arm(input logic pol, input logic pha, input logic lf, input int bits,
                           input logic [31:0] word);
    s_cpol = pol; s_cpha = pha; s_lsb = lf; slv_bits = bits; slv_tx = word;
    slv_d = 0; slv_s = 0; slv_rx = 32'd0;
    if (!pha) begin
      slv_miso = word[lf ? 0 : bits - 1];
      slv_d = 1;
    end
    slv_on = 1'b1;
  endtask

  always @(spi.sck) begin
    if (slv_on) begin
      if ((spi.sck != s_cpol) == !s_cpha) begin
        if (slv_s < slv_bits) slv_rx[s_lsb ? slv_s : slv_bits - 1 - slv_s] = spi.mosi;
        slv_s++;
      end else begin
        if (slv_d < slv_bits) slv_miso = slv_tx[s_lsb ? slv_d : slv_bits - 1 - slv_d];
        slv_d++;
      end
    end
  end

  // Negedge monitor
  int          cyc = 0, rx_cnt = 0, nss_low = 0, nss_rise = 0, rdy_pulse = 0, hs_cnt = 0;
  logic        nss_prev_all = 1'b1;
  logic [31:0] rx_log [4];
  int          rx_cyc [4];

  always @(negedge clk) begin
    cyc++;
    if (rx_valid) begin
      rx_log[rx_cnt % 4] = rx_data;
      rx_cyc[rx_cnt % 4] = cyc;
      rx_cnt++;
    end
    if (!(&spi.nss)) nss_low++;
    if ((&spi.nss) && !nss_prev_all) nss_rise++;
    nss_prev_all = &spi.nss;
    if (busy && tx_ready) rdy_pulse++;
    if (tx_valid && tx_ready) hs_cnt++;
  end

  task automatic start_frame(input logic [31:0] data);
    tx_data = data;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (spi.sck !== 1'b0) begin failures++; $display("FAIL rst_sck: got %b want 0", spi.sck); end
    checks++; if (spi.nss !== 4'hF) begin failures++; $display("FAIL rst_nss: got %b want 1111", spi.nss); end
    checks++; if (spi.mosi !== 1'b0) begin failures++; $display("FAIL rst_mosi: got %b want 0", spi.mosi); end
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rxv: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 32'd0) begin failures++; $display("FAIL rst_rxd: got %h want 0", rx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mode0_msb();
    int r0, n0;
    bit ok;
    cpol = 0; cpha = 0; lsb = 0; ass = 1; dtb = SPI_DTB_8; nss = 4'b0001; div = 16'd1; loop = 1;
    slave_arm(1'b0, 1'b0, 1'b0, 8, 32'd0);
    r0 = rx_cnt; n0 = nss_low;
    start_frame(32'hA5);
    repeat (3) @(posedge clk); #1;
    checks++; if (spi.nss !== 4'b1110) begin failures++; $display("FAIL m0_nss: got %b want 1110", spi.nss); end
    wait_idle(200, ok);
    slv_on = 0;
    checks++; if (!ok) begin failures++; $display("FAIL m0_timeout: got busy want idle"); end
    checks++; if (nss_low - n0 !== 36) begin failures++; $display("FAIL m0_nss_cycles: got %0d want 36", nss_low - n0); end
    checks++; if (slv_rx !== 32'hA5) begin failures++; $display("FAIL m0_mosi_seq: got %h want a5", slv_rx); end
    checks++; if (rx_cnt - r0 !== 1) begin failures++; $display("FAIL m0_rx_pulses: got %0d want 1", rx_cnt - r0); end
    checks++; if (rx_data !== 32'h000000A5) begin failures++; $display("FAIL m0_rx_data: got %h want 000000a5", rx_data); end
  endtask

  task automatic test_mode3_lsb();
    bit ok;
    cpol = 1; cpha = 1; lsb = 1; ass = 1; dtb = SPI_DTB_32; nss = 4'b0001; div = 16'd0; loop = 0;
    #1;
    checks++; if (spi.sck !== 1'b1) begin failures++; $display("FAIL m3_sck_idle: got %b want 1", spi.sck); end
    slave_arm(1'b1, 1'b1, 1'b1, 32, 32'h80000001);
    start_frame(32'h12345678);
    wait_idle(200, ok);
    slv_on = 0;
    checks++; if (!ok) begin failures++; $display("FAIL m3_timeout: got busy want idle"); end
    checks++; if (slv_s !== 32) begin failures++; $display("FAIL m3_edges: got %0d want 32", slv_s); end
    checks++; if (slv_rx !== 32'h12345678) begin failures++; $display("FAIL m3_mosi: got %h want 12345678", slv_rx); end
    checks++; if (rx_data !== 32'h80000001) begin failures++; $display("FAIL m3_rx_data: got %h want 80000001", rx_data); end
    checks++; if (spi.sck !== 1'b1) begin failures++; $display("FAIL m3_sck_end: got %b want 1", spi.sck); end
  endtask

  task automatic test_back_to_back();
    int r0, h0, nr0, p0;
    bit ok;
    cpol = 0; cpha = 0; lsb = 0; ass = 1; dtb = SPI_DTB_16; nss = 4'b0010; div = 16'd2; loop = 1;
    r0 = rx_cnt; h0 = hs_cnt; nr0 = nss_rise; p0 = rdy_pulse;
    tx_data = 32'hBEEF;
    tx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (hs_cnt - h0 == 1) tx_data = 32'hCAFE;
      if (hs_cnt - h0 >= 2) break;
    end
    tx_valid = 1'b0;
    wait_idle(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_timeout: got busy want idle"); end
    checks++; if (hs_cnt - h0 !== 2) begin failures++; $display("FAIL burst_hs: got %0d want 2", hs_cnt - h0); end
    checks++; if (rx_cnt - r0 !== 2) begin failures++; $display("FAIL burst_rx_cnt: got %0d want 2", rx_cnt - r0); end
    checks++; if (rx_log[r0 % 4] !== 32'hBEEF) begin failures++; $display("FAIL burst_rx0: got %h want beef", rx_log[r0 % 4]); end
    checks++; if (rx_log[(r0 + 1) % 4] !== 32'hCAFE) begin failures++; $display("FAIL burst_rx1: got %h want cafe", rx_log[(r0 + 1) % 4]); end
    checks++; if (rx_cyc[(r0 + 1) % 4] - rx_cyc[r0 % 4] !== 96) begin failures++; $display("FAIL burst_gap: got %0d want 96", rx_cyc[(r0 + 1) % 4] - rx_cyc[r0 % 4]); end
    checks++; if (nss_rise - nr0 !== 1) begin failures++; $display("FAIL burst_nss_rise: got %0d want 1", nss_rise - nr0); end
    checks++; if (rdy_pulse - p0 !== 2) begin failures++; $display("FAIL burst_ready: got %0d want 2", rdy_pulse - p0); end
  endtask

  task automatic test_abort();
    int r0, edges;
    logic prev;
    bit ok;
    cpol = 1; cpha = 0; lsb = 0; ass = 1; dtb = SPI_DTB_8; nss = 4'b0100; div = 16'd1; loop = 1;
    r0 = rx_cnt;
    start_frame(32'h5A);
    prev = spi.sck;
    edges = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (spi.sck !== prev) begin
        edges++;
        prev = spi.sck;
      end
      if (edges == 5) break;
    end
    checks++; if (edges !== 5) begin failures++; $display("FAIL abort_edges: got %0d want 5", edges); end
    en = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (spi.nss !== 4'hF) begin failures++; $display("FAIL abort_nss: got %b want 1111", spi.nss); end
    checks++; if (spi.sck !== 1'b1) begin failures++; $display("FAIL abort_sck: got %b want 1", spi.sck); end
    repeat (20) @(negedge clk);
    checks++; if (rx_cnt - r0 !== 0) begin failures++; $display("FAIL abort_rxv: got %0d want 0", rx_cnt - r0); end
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    start_frame(32'h96);
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL abort_timeout: got busy want idle"); end
    checks++; if (rx_data !== 32'h96) begin failures++; $display("FAIL abort_next_rx: got %h want 96", rx_data); end
    checks++; if (rx_cnt - r0 !== 1) begin failures++; $display("FAIL abort_next_cnt: got %0d want 1", rx_cnt - r0); end
  endtask

  task automatic test_soft_nss();
    int viol;
    bit ok;
    cpol = 0; cpha = 1; lsb = 0; ass = 0; dtb = SPI_DTB_8; div = 16'd0; loop = 1;
    nss = 4'b0110;
    #1;
    checks++; if (spi.nss !== 4'b1001) begin failures++; $display("FAIL sw_nss_idle: got %b want 1001", spi.nss); end
    start_frame(32'h3C);
    viol = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (spi.nss !== 4'b1001) viol++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    checks++; if (!ok) begin failures++; $display("FAIL sw_timeout: got busy want idle"); end
    checks++; if (viol !== 0) begin failures++; $display("FAIL sw_nss_frame: got %0d bad cycles want 0", viol); end
    checks++; if (rx_data !== 32'h3C) begin failures++; $display("FAIL sw_rx: got %h want 3c", rx_data); end
    ass = 1; nss = 4'b0000;
  endtask

  task automatic test_reset_midframe();
    cpol = 1; cpha = 0; lsb = 0; ass = 1; dtb = SPI_DTB_8; nss = 4'b0001; div = 16'd1; loop = 1;
    start_frame(32'hFF);
    repeat (8) @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mrst_pre_busy: got %b want 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (spi.sck !== 1'b0) begin failures++; $display("FAIL mrst_sck: got %b want 0", spi.sck); end
    checks++; if (spi.nss !== 4'hF) begin failures++; $display("FAIL mrst_nss: got %b want 1111", spi.nss); end
    checks++; if (spi.mosi !== 1'b0) begin failures++; $display("FAIL mrst_mosi: got %b want 0", spi.mosi); end
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL mrst_ready: got %b want 0", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL mrst_rxv: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 32'd0) begin failures++; $display("FAIL mrst_rxd: got %h want 0", rx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mrst_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode0_msb();
    test_mode3_lsb();
    test_back_to_back();
    test_abort();
    test_soft_nss();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
